// File: rtl/shift_reg8_if.sv
// Data, mode and status signals of the slow-strobe shift register.
// The slave modport is the register; the master modport is whoever drives it.
interface shift_reg8_if #(
  parameter int WIDTH = 8
);
  logic             slow_clk;
  logic [2:0]       mode;
  logic             ser_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic [3:0]       shift_cnt;
  logic             done;

  modport slave (
    input  slow_clk,
    input  mode,
    input  ser_in,
    input  d,
    output q,
    output ser_out,
    output shift_cnt,
    output done
  );

  modport master (
    output slow_clk,
    output mode,
    output ser_in,
    output d,
    input  q,
    input  ser_out,
    input  shift_cnt,
    input  done
  );
endinterface

// File: rtl/shift_reg8.sv
// Multi-mode shift register clocked by the system clock.
// It performs one shift or rotate per synchronized rising edge of the divider strobe.
module shift_reg8 #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  shift_reg8_if.slave  bus
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_ROTL  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ASR   = 3'b101;
  localparam logic [2:0] M_LOAD  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [3:0] CNT_SAT = 4'(CNT_MAX);
  localparam logic [3:0] CNT_PRE = 4'(CNT_MAX - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_armed;
  logic [1:0]       r_fill;
  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic [3:0]       r_cnt;
  logic             r_done;

  logic             w_step;
  logic             w_shift;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ser_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_done_nxt;

  assign w_step = r_sync2 & ~r_prev & r_armed;

  // Next register, serial-out, count and done values for the selected mode
  always_comb begin
    w_q_nxt    = r_q;
    w_ser_nxt  = r_ser_out;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    w_shift    = 1'b0;
    case (bus.mode)
      M_LOAD: begin
        w_q_nxt   = bus.d;
        w_cnt_nxt = 4'd0;
      end
      M_CLEAR: begin
        w_q_nxt   = '0;
        w_cnt_nxt = 4'd0;
        w_ser_nxt = 1'b0;
      end
      M_SHL: begin
        w_shift = w_step;
        if (w_step) begin
          w_q_nxt   = {r_q[WIDTH-2:0], bus.ser_in};
          w_ser_nxt = r_q[WIDTH-1];
        end else begin
          w_q_nxt = r_q;
        end
      end
      M_SHR: begin
        w_shift = w_step;
        if (w_step) begin
          w_q_nxt   = {bus.ser_in, r_q[WIDTH-1:1]};
          w_ser_nxt = r_q[0];
        end else begin
          w_q_nxt = r_q;
        end
      end
      M_ROTL: begin
        w_shift = w_step;
        if (w_step) begin
          w_q_nxt   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_ser_nxt = r_q[WIDTH-1];
        end else begin
          w_q_nxt = r_q;
        end
      end
      M_ROTR: begin
        w_shift = w_step;
        if (w_step) begin
          w_q_nxt   = {r_q[0], r_q[WIDTH-1:1]};
          w_ser_nxt = r_q[0];
        end else begin
          w_q_nxt = r_q;
        end
      end
      M_ASR: begin
        w_shift = w_step;
        if (w_step) begin
          w_q_nxt   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_ser_nxt = r_q[0];
        end else begin
          w_q_nxt = r_q;
        end
      end
      M_HOLD: begin
        w_shift = 1'b0;
      end
      default: begin
        w_shift = 1'b0;
      end
    endcase

    if (w_shift) begin
      w_cnt_nxt  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 4'd1;
      w_done_nxt = (r_cnt == CNT_PRE);
    end else begin
      w_done_nxt = 1'b0;
    end
  end

  // Strobe synchronizer, edge detector and datapath state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_armed   <= 1'b0;
      r_fill    <= 2'b00;
      r_q       <= '0;
      r_ser_out <= 1'b0;
      r_cnt     <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_sync1   <= bus.slow_clk;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      // Arm only once r_sync2 holds a real sample, so a strobe already high at release never steps
      r_fill    <= {r_fill[0], 1'b1};
      r_armed   <= r_armed | (r_fill[1] & ~r_sync2);
      r_q       <= w_q_nxt;
      r_ser_out <= w_ser_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.q         = r_q;
  assign bus.ser_out   = r_ser_out;
  assign bus.shift_cnt = r_cnt;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_shift_reg8.sv
// Directed bench for shift_reg8: a vector table of load/shift/hold/clear steps
// plus hand-written sequences for reset arming, step latency, load collision and async reset.
module tb_shift_reg8;

  logic clk;
  logic reset;

  shift_reg8_if #(.WIDTH(8)) bus ();

  shift_reg8 #(.WIDTH(8), .CNT_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic       ser_in;
    logic [7:0] d;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    int         dn;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full strobe period: 4 cycles high, 4 low; counts cycles with done high
  task automatic slow_pulse(output int dn);
    dn = 0;
    bus.slow_clk = 1'b1;
    repeat (4) begin
      tick();
      if (bus.done) dn++;
    end
    bus.slow_clk = 1'b0;
    repeat (4) begin
      tick();
      if (bus.done) dn++;
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] q, input logic so,
                           input logic [3:0] cnt);
    chk({tag, ".q"}, 32'(bus.q), 32'(q));
    chk({tag, ".ser_out"}, 32'(bus.ser_out), 32'(so));
    chk({tag, ".cnt"}, 32'(bus.shift_cnt), 32'(cnt));
  endtask

  initial begin
    int dn;
    vecs[0]  = '{3'b110, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'd0, 0};
    vecs[1]  = '{3'b001, 1'b1, 8'h00, 8'h4B, 1'b1, 4'd1, 0};
    vecs[2]  = '{3'b001, 1'b1, 8'h00, 8'h97, 1'b0, 4'd2, 0};
    vecs[3]  = '{3'b001, 1'b1, 8'h00, 8'h2F, 1'b1, 4'd3, 0};
    vecs[4]  = '{3'b001, 1'b1, 8'h00, 8'h5F, 1'b0, 4'd4, 0};
    vecs[5]  = '{3'b001, 1'b1, 8'h00, 8'hBF, 1'b0, 4'd5, 0};
    vecs[6]  = '{3'b001, 1'b1, 8'h00, 8'h7F, 1'b1, 4'd6, 0};
    vecs[7]  = '{3'b001, 1'b1, 8'h00, 8'hFF, 1'b0, 4'd7, 0};
    vecs[8]  = '{3'b001, 1'b1, 8'h00, 8'hFF, 1'b1, 4'd8, 1};
    vecs[9]  = '{3'b001, 1'b1, 8'h00, 8'hFF, 1'b1, 4'd8, 0};
    vecs[10] = '{3'b000, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd8, 0};
    vecs[11] = '{3'b000, 1'b1, 8'h00, 8'hFF, 1'b1, 4'd8, 0};
    vecs[12] = '{3'b000, 1'b0, 8'h00, 8'hFF, 1'b1, 4'd8, 0};
    vecs[13] = '{3'b111, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 0};
    vecs[14] = '{3'b110, 1'b0, 8'h81, 8'h81, 1'b0, 4'd0, 0};
    vecs[15] = '{3'b100, 1'b0, 8'h00, 8'hC0, 1'b1, 4'd1, 0};
    vecs[16] = '{3'b110, 1'b0, 8'h80, 8'h80, 1'b1, 4'd0, 0};
    vecs[17] = '{3'b101, 1'b0, 8'h00, 8'hC0, 1'b0, 4'd1, 0};
    vecs[18] = '{3'b101, 1'b0, 8'h00, 8'hE0, 1'b0, 4'd2, 0};
    vecs[19] = '{3'b101, 1'b0, 8'h00, 8'hF0, 1'b0, 4'd3, 0};
    vecs[20] = '{3'b011, 1'b0, 8'h00, 8'hE1, 1'b1, 4'd4, 0};
    vecs[21] = '{3'b010, 1'b0, 8'h00, 8'h70, 1'b1, 4'd5, 0};
    vecs[22] = '{3'b010, 1'b1, 8'h00, 8'hB8, 1'b0, 4'd6, 0};

    reset        = 1'b0;
    bus.slow_clk = 1'b1;
    bus.mode     = 3'b001;
    bus.ser_in   = 1'b1;
    bus.d        = 8'h00;
    repeat (3) tick();
    chk_state("reset", 8'h00, 1'b0, 4'd0);
    chk("reset.done", 32'(bus.done), 32'd0);

    // Release with the strobe already high: no step may occur
    reset = 1'b1;
    repeat (6) tick();
    chk_state("rel_high", 8'h00, 1'b0, 4'd0);
    bus.slow_clk = 1'b0;
    repeat (4) tick();
    chk_state("rel_low", 8'h00, 1'b0, 4'd0);
    bus.slow_clk = 1'b1;
    tick();
    chk("lat.k", 32'(bus.q), 32'h00);
    tick();
    chk("lat.k1", 32'(bus.q), 32'h00);
    tick();
    chk_state("lat.k2", 8'h01, 1'b0, 4'd1);
    bus.slow_clk = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < NV; i++) begin
      bus.mode   = vecs[i].mode;
      bus.ser_in = vecs[i].ser_in;
      bus.d      = vecs[i].d;
      if (vecs[i].mode == 3'b110 || vecs[i].mode == 3'b111) begin
        tick();
        dn = bus.done ? 1 : 0;
        bus.mode = 3'b000;
      end else begin
        slow_pulse(dn);
      end
      chk_state($sformatf("vec%0d", i), vecs[i].q, vecs[i].so, vecs[i].cnt);
      chk($sformatf("vec%0d.done_cycles", i), 32'(dn), 32'(vecs[i].dn));
    end

    // Load lands on the same edge as a pending step: load wins
    bus.mode = 3'b110;
    bus.d    = 8'h0F;
    tick();
    bus.mode   = 3'b001;
    bus.ser_in = 1'b0;
    bus.slow_clk = 1'b1;
    tick();
    tick();
    bus.mode = 3'b110;
    bus.d    = 8'h3C;
    tick();
    chk("coll.q", 32'(bus.q), 32'h3C);
    chk("coll.cnt", 32'(bus.shift_cnt), 32'd0);
    bus.mode = 3'b000;
    bus.slow_clk = 1'b0;
    repeat (4) tick();
    chk("coll.q_after", 32'(bus.q), 32'h3C);
    chk("coll.cnt_after", 32'(bus.shift_cnt), 32'd0);

    // Five shifts, then an asynchronous reset between clock edges
    bus.mode   = 3'b001;
    bus.ser_in = 1'b1;
    repeat (5) slow_pulse(dn);
    chk_state("pre_rst", 8'h9F, 1'b1, 4'd5);
    #3;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 8'h00, 1'b0, 4'd0);
    chk("async_rst.done", 32'(bus.done), 32'd0);
    #1;
    reset = 1'b1;
    repeat (4) tick();
    slow_pulse(dn);
    chk_state("post_rst", 8'h01, 1'b0, 4'd1);
    chk("post_rst.done_cycles", 32'(dn), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
